data_memory_ctrl: RTL and testbench

Parametrised single-clock data memory for the 16-bit CPU datapath. It adds the following:
- per-byte write strobes;
- a configurable read pipeline with a valid flag;
- a hardware clear sequencer that zeroes the array after reset or on request;
- out-of-range address detection for depths that are not a power of two.

It sits between the execute stage and the load/store writeback path.

---
 rtl/data_memory_ctrl_pkg.sv | 13 +
 rtl/data_memory_ctrl_ram_core.sv | 37 +++
 rtl/data_memory_ctrl.sv | 177 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and default widths for the CPU data memory.
package CPU_package;

  localparam int unsigned DATA_WIDTH          = 16;
  localparam int unsigned ADDRESS_WIDTH       = 8;
  localparam int unsigned DM_READ_LATENCY_MAX = 2;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

endpackage

// File: rtl/data_memory_ctrl_ram_core.sv
// Byte-strobed storage array with a registered read-first port; no reset so it maps to block RAM.
module dm_ram_core #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DEPTH         = 256
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [ADDRESS_WIDTH-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      re_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read samples the old word, so a same-cycle write is not visible until the next read.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
    if (we_i) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: clear sweeper FSM, range check, read pipeline and error flag
// wrapped around dm_ram_core.
module data_memory_ctrl #(
  parameter int unsigned           DATA_WIDTH    = CPU_package::DATA_WIDTH,
  parameter int unsigned           ADDRESS_WIDTH = CPU_package::ADDRESS_WIDTH,
  parameter int unsigned           DEPTH         = 2**ADDRESS_WIDTH,
  parameter int unsigned           READ_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDRESS_WIDTH-1:0]  DM_address,
  input  logic                      Write_Enable,
  input  logic [DATA_WIDTH/8-1:0]   Byte_Enable,
  input  logic [DATA_WIDTH-1:0]     DATA_WRITE,
  input  logic                      Read_Enable,
  input  logic                      Clear_Request,
  output logic [DATA_WIDTH-1:0]     DATA_READ,
  output logic                      Read_Valid,
  output logic                      Busy,
  output logic                      Error
);

  import CPU_package::*;

  localparam int unsigned              NB        = DATA_WIDTH / 8;
  localparam int unsigned              CW        = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  dm_state_t                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     error_q, error_d;
  logic                     rd_vld_q, rd_vld_d;
  logic                     rd_oor_q, rd_oor_d;
  logic                     rvalid_q;
  logic [DATA_WIDTH-1:0]    dout_q;

  logic                     in_range;
  logic                     ram_we;
  logic                     ram_re;
  logic [NB-1:0]            ram_be;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic [DATA_WIDTH-1:0]    ram_rdata;
  logic [DATA_WIDTH-1:0]    s0_data;
  logic                     tail_vld;
  logic [DATA_WIDTH-1:0]    tail_data;

  // Widened compare so a full power-of-two depth never reports out of range.
  assign in_range = (CW'(DM_address) < CW'(DEPTH));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DM_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      DM_CLEAR: if (cnt_q == LAST_ADDR) state_d = DM_READY;
      DM_READY: if (Clear_Request)      state_d = DM_CLEAR;
      default:                          state_d = DM_CLEAR;
    endcase
  end

  // Output / datapath control; a Clear_Request cycle drops any concurrent access.
  always_comb begin
    cnt_d     = '0;
    error_d   = 1'b0;
    rd_vld_d  = 1'b0;
    rd_oor_d  = rd_oor_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = '0;
    ram_addr  = DM_address;
    ram_wdata = DATA_WRITE;
    case (state_q)
      DM_CLEAR: begin
        cnt_d     = cnt_q + ADDRESS_WIDTH'(1);
        ram_we    = 1'b1;
        ram_be    = '1;
        ram_addr  = cnt_q;
        ram_wdata = CLEAR_VALUE;
      end
      DM_READY: begin
        if (!Clear_Request) begin
          ram_we   = Write_Enable && in_range;
          ram_be   = Byte_Enable;
          ram_re   = Read_Enable && in_range;
          rd_vld_d = Read_Enable;
          if (Read_Enable) rd_oor_d = !in_range;
          error_d  = (Write_Enable || Read_Enable) && !in_range;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == DM_CLEAR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b1;
      error_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      error_q  <= error_d;
      rd_vld_q <= rd_vld_d;
      rd_oor_q <= rd_oor_d;
    end
  end

  dm_ram_core #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH         (DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  // Out-of-range reads never touch the array; they return zero.
  assign s0_data = rd_oor_q ? '0 : ram_rdata;

  // Optional extra stage for the longer read latency.
  if (READ_LATENCY >= DM_READ_LATENCY_MAX) begin : g_ext
    logic                  vld1_q;
    logic [DATA_WIDTH-1:0] dat1_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld1_q <= 1'b0;
        dat1_q <= '0;
      end else begin
        vld1_q <= rd_vld_q;
        if (rd_vld_q) dat1_q <= s0_data;
      end
    end

    assign tail_vld  = vld1_q;
    assign tail_data = dat1_q;
  end else begin : g_short
    assign tail_vld  = rd_vld_q;
    assign tail_data = s0_data;
  end

  // Output register holds the last returned word between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      rvalid_q <= tail_vld;
      if (tail_vld) dout_q <= tail_data;
    end
  end

  assign DATA_READ  = dout_q;
  assign Read_Valid = rvalid_q;
  assign Busy       = busy_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl against a queue-based behavioural memory model.
module tb_data_memory_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam int unsigned LAT   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] DM_address;
  logic          Write_Enable;
  logic [DW/8-1:0] Byte_Enable;
  logic [DW-1:0] DATA_WRITE;
  logic          Read_Enable;
  logic          Clear_Request;
  logic [DW-1:0] DATA_READ;
  logic          Read_Valid;
  logic          Busy;
  logic          Error;

  always #5 clock = ~clock;

  data_memory_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .DEPTH         (DEPTH),
    .READ_LATENCY  (LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .DM_address    (DM_address),
    .Write_Enable  (Write_Enable),
    .Byte_Enable   (Byte_Enable),
    .DATA_WRITE    (DATA_WRITE),
    .Read_Enable   (Read_Enable),
    .Clear_Request (Clear_Request),
    .DATA_READ     (DATA_READ),
    .Read_Valid    (Read_Valid),
    .Busy          (Busy),
    .Error         (Error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: array contents, remaining sweep cycles, and reads due at a given cycle.
  logic [DW-1:0] m_mem [DEPTH];
  int            sweep_left;
  int            cyc = 0;
  int            due_q [$];
  logic [DW-1:0] val_q [$];
  logic          exp_valid, exp_err, exp_busy;
  logic [DW-1:0] exp_data;

  task automatic model_reset();
    sweep_left = int'(DEPTH);
    due_q.delete();
    val_q.delete();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_busy  = 1'b1;
    exp_data  = '0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
  endtask

  // Drive one request cycle, advance one clock, update the model, settle 1 time unit past the edge.
  task automatic step(input logic we, input logic re, input logic clr, input logic [AW-1:0] addr,
                      input logic [DW/8-1:0] be, input logic [DW-1:0] wd);
    logic oor;
    Write_Enable  = we;
    Read_Enable   = re;
    Clear_Request = clr;
    DM_address    = addr;
    Byte_Enable   = be;
    DATA_WRITE    = wd;
    @(posedge clock);
    cyc++;
    exp_err = 1'b0;
    if (sweep_left > 0) begin
      sweep_left--;
    end else if (clr) begin
      sweep_left = int'(DEPTH);
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    end else begin
      oor     = (int'(addr) >= int'(DEPTH));
      exp_err = (we || re) && oor;
      if (re) begin
        due_q.push_back(cyc + int'(LAT));
        if (oor) val_q.push_back('0);
        else     val_q.push_back(m_mem[addr]);
      end
      if (we && !oor) begin
        for (int b = 0; b < int'(DW/8); b++)
          if (be[b]) m_mem[addr][8*b +: 8] = wd[8*b +: 8];
      end
    end
    exp_busy  = (sweep_left > 0);
    exp_valid = 1'b0;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      exp_valid = 1'b1;
      exp_data  = val_q.pop_front();
      void'(due_q.pop_front());
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    Write_Enable = 1'b0; Read_Enable = 1'b0; Clear_Request = 1'b0;
    DM_address = '0; Byte_Enable = '0; DATA_WRITE = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if ({DATA_READ, Read_Valid, Busy, Error} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values got dr=%h rv=%b busy=%b err=%b want 0000/0/1/0",
               DATA_READ, Read_Valid, Busy, Error);
    end
    reset = 1'b0;
    n = 0;
    // Random requests during the sweep must all be dropped.
    do begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), DW'($urandom));
      n++;
      n_tests++;
      if ({Busy, Read_Valid, Error, DATA_READ} !== {exp_busy, exp_valid, exp_err, exp_data}) begin
        n_fail++;
        $display("FAIL reset_sweep cyc=%0d got busy=%b rv=%b err=%b dr=%h want %b %b %b %h",
                 cyc, Busy, Read_Valid, Error, DATA_READ, exp_busy, exp_valid, exp_err, exp_data);
      end
    end while (Busy && n < int'(DEPTH) + 10);
    n_tests++;
    if (n != int'(DEPTH)) begin
      n_fail++;
      $display("FAIL reset_sweep_len got %0d edges want %0d", n, DEPTH);
    end
    step(1'b0, 1'b1, 1'b0, 8'd0,   '0, '0);
    step(1'b0, 1'b1, 1'b0, 8'd199, '0, '0);
    step(1'b0, 1'b1, 1'b0, 8'd100, '0, '0);
    n_tests++;
    if (Read_Valid !== 1'b1 || DATA_READ !== 16'h0000) begin
      n_fail++;
      $display("FAIL cleared_read got rv=%b dr=%h want 1/0000", Read_Valid, DATA_READ);
    end
    repeat (2) begin
      idle();
      n_tests++;
      if ({Busy, Read_Valid, Error, DATA_READ} !== {exp_busy, exp_valid, exp_err, exp_data}) begin
        n_fail++;
        $display("FAIL cleared_reads cyc=%0d got rv=%b dr=%h want %b %h",
                 cyc, Read_Valid, DATA_READ, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_byte_strobes();
    step(1'b1, 1'b0, 1'b0, 8'd10, 2'b11, 16'hA5C3);
    step(1'b1, 1'b0, 1'b0, 8'd10, 2'b01, 16'hFF00);
    step(1'b0, 1'b1, 1'b0, 8'd10, 2'b00, 16'h0000);
    idle();
    idle();
    n_tests++;
    if (Read_Valid !== 1'b1 || DATA_READ !== 16'hA500) begin
      n_fail++;
      $display("FAIL byte_strobe got rv=%b dr=%h want 1/a500", Read_Valid, DATA_READ);
    end
    n_tests++;
    if (exp_data !== 16'hA500) begin
      n_fail++;
      $display("FAIL byte_strobe_model got %h want a500", exp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] pat;
    step(1'b1, 1'b0, 1'b0, 8'd5, 2'b11, 16'h1111);
    step(1'b1, 1'b1, 1'b0, 8'd5, 2'b11, 16'h2222);
    step(1'b0, 1'b1, 1'b0, 8'd5, 2'b00, 16'h0000);
    idle();
    n_tests++;
    if (Read_Valid !== 1'b1 || DATA_READ !== 16'h1111) begin
      n_fail++;
      $display("FAIL read_first got rv=%b dr=%h want 1/1111", Read_Valid, DATA_READ);
    end
    idle();
    n_tests++;
    if (Read_Valid !== 1'b1 || DATA_READ !== 16'h2222) begin
      n_fail++;
      $display("FAIL write_visible got rv=%b dr=%h want 1/2222", Read_Valid, DATA_READ);
    end
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(1'b0, 1'b1, 1'b0, AW'($urandom_range(0, 199)), '0, '0);
      else       idle();
      pat = {pat[5:0], Read_Valid};
      n_tests++;
      if ({Busy, Read_Valid, Error, DATA_READ} !== {exp_busy, exp_valid, exp_err, exp_data}) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got rv=%b dr=%h want %b %h",
                 cyc, Read_Valid, DATA_READ, exp_valid, exp_data);
      end
    end
    n_tests++;
    if (pat !== 7'b0011110) begin
      n_fail++;
      $display("FAIL back_to_back_valid got %b want 0011110", pat);
    end
  endtask

  task automatic test_out_of_range();
    step(1'b1, 1'b0, 1'b0, 8'd250, 2'b11, 16'hBEEF);
    n_tests++;
    if (Error !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_write_err got %b want 1", Error);
    end
    idle();
    n_tests++;
    if (Error !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_err_pulse got %b want 0", Error);
    end
    step(1'b0, 1'b1, 1'b0, 8'd250, 2'b00, 16'h0000);
    n_tests++;
    if (Error !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_read_err got %b want 1", Error);
    end
    idle();
    idle();
    n_tests++;
    if (Read_Valid !== 1'b1 || DATA_READ !== 16'h0000) begin
      n_fail++;
      $display("FAIL oor_read_data got rv=%b dr=%h want 1/0000", Read_Valid, DATA_READ);
    end
    step(1'b1, 1'b1, 1'b0, 8'd250, 2'b11, 16'hBEEF);
    n_tests++;
    if (Error !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_rw_err got %b want 1", Error);
    end
    idle();
    n_tests++;
    if (Error !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_rw_single got %b want 0", Error);
    end
    // Possible alias targets of address 250 must keep their model contents.
    step(1'b0, 1'b1, 1'b0, 8'd50,  '0, '0);
    step(1'b0, 1'b1, 1'b0, 8'd122, '0, '0);
    repeat (3) begin
      idle();
      n_tests++;
      if ({Busy, Read_Valid, Error, DATA_READ} !== {exp_busy, exp_valid, exp_err, exp_data}) begin
        n_fail++;
        $display("FAIL oor_alias cyc=%0d got rv=%b dr=%h want %b %h",
                 cyc, Read_Valid, DATA_READ, exp_valid, exp_data);
      end
    end
  endtask

  task automatic test_clear_during_traffic();
    int n;
    int rv_cnt;
    step(1'b1, 1'b0, 1'b0, 8'd3, 2'b11, 16'h3333);
    step(1'b0, 1'b1, 1'b0, 8'd3, 2'b00, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 8'd3, 2'b11, 16'hFFFF);
    n = 0;
    rv_cnt = 0;
    do begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
           AW'($urandom_range(0, 199)), 2'b11, DW'($urandom));
      n++;
      if (Read_Valid === 1'b1) rv_cnt++;
      if (n == 1) begin
        n_tests++;
        if (Read_Valid !== 1'b1 || DATA_READ !== 16'h3333) begin
          n_fail++;
          $display("FAIL inflight_read got rv=%b dr=%h want 1/3333", Read_Valid, DATA_READ);
        end
      end
      n_tests++;
      if ({Busy, Read_Valid, Error, DATA_READ} !== {exp_busy, exp_valid, exp_err, exp_data}) begin
        n_fail++;
        $display("FAIL clear_sweep cyc=%0d got busy=%b rv=%b err=%b dr=%h want %b %b %b %h",
                 cyc, Busy, Read_Valid, Error, DATA_READ, exp_busy, exp_valid, exp_err, exp_data);
      end
    end while (Busy && n < int'(DEPTH) + 10);
    n_tests++;
    if (n != int'(DEPTH) || rv_cnt != 1) begin
      n_fail++;
      $display("FAIL clear_len got %0d edges %0d valids want %0d edges 1 valid", n, rv_cnt, DEPTH);
    end
    step(1'b0, 1'b1, 1'b0, 8'd3, 2'b00, 16'h0000);
    idle();
    idle();
    n_tests++;
    if (Read_Valid !== 1'b1 || DATA_READ !== 16'h0000) begin
      n_fail++;
      $display("FAIL cleared_addr3 got rv=%b dr=%h want 1/0000", Read_Valid, DATA_READ);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    step(1'b1, 1'b0, 1'b0, 8'd7, 2'b11, 16'h5A5A);
    step(1'b0, 1'b1, 1'b0, 8'd7, 2'b00, 16'h0000);
    idle();
    idle();
    n_tests++;
    if (Read_Valid !== 1'b1 || DATA_READ !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL pre_reset_read got rv=%b dr=%h want 1/5a5a", Read_Valid, DATA_READ);
    end
    step(1'b0, 1'b0, 1'b1, 8'd0, 2'b00, 16'h0000);
    repeat (57) idle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({DATA_READ, Read_Valid, Busy, Error} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_sweep_reset got dr=%h rv=%b busy=%b err=%b want 0000/0/1/0",
               DATA_READ, Read_Valid, Busy, Error);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    n = 0;
    do begin
      idle();
      n++;
      n_tests++;
      if ({Busy, Read_Valid, Error, DATA_READ} !== {exp_busy, exp_valid, exp_err, exp_data}) begin
        n_fail++;
        $display("FAIL resweep cyc=%0d got busy=%b rv=%b err=%b dr=%h want %b %b %b %h",
                 cyc, Busy, Read_Valid, Error, DATA_READ, exp_busy, exp_valid, exp_err, exp_data);
      end
    end while (Busy && n < int'(DEPTH) + 10);
    n_tests++;
    if (n != int'(DEPTH)) begin
      n_fail++;
      $display("FAIL resweep_len got %0d edges want %0d", n, DEPTH);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 255));
      else                           a = AW'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0),
           a, 2'($urandom_range(0, 3)), DW'($urandom));
      n_tests++;
      if ({Busy, Read_Valid, Error, DATA_READ} !== {exp_busy, exp_valid, exp_err, exp_data}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got busy=%b rv=%b err=%b dr=%h want %b %b %b %h",
                 cyc, Busy, Read_Valid, Error, DATA_READ, exp_busy, exp_valid, exp_err, exp_data);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_strobes();
    test_back_to_back();
    test_out_of_range();
    test_clear_during_traffic();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
